// File: rtl/piso_shift_param.sv
// Parallel-in/serial-out shift register with a valid/ready load handshake.
// Supports selectable bit order, per-cycle shift enable and back-to-back reloads.
module piso_shift_param #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         pin,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic                     shift_en,
  output logic                     sout,
  output logic                     sout_valid,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         q,
  output logic [$clog2(WIDTH)-1:0] cnt
);

  // state | meaning
  // IDLE  | no word in flight, sout = IDLE_LEVEL, ready for a new word
  // SHIFT | word in flight, sout = current bit, cnt = bits left after it

  localparam int CW = $clog2(WIDTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state;
  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] q_shift;

  // The final bit being taken frees the register, so a new word can land with no gap.
  assign last_bit   = (state == ST_SHIFT) && (cnt == '0) && shift_en;
  assign load_ready = (state == ST_IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  assign busy       = (state == ST_SHIFT);
  assign sout_valid = busy;
  assign sout       = busy ? (MSB_FIRST ? q[WIDTH-1] : q[0]) : IDLE_LEVEL;
  assign q_shift    = MSB_FIRST ? {q[WIDTH-2:0], 1'b0} : {1'b0, q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      q     <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= last_bit;
      if (accept) begin
        q     <= pin;
        cnt   <= CW'(WIDTH - 1);
        state <= ST_SHIFT;
      end else if (last_bit) begin
        q     <= '0;
        state <= ST_IDLE;
      end else if (busy && shift_en) begin
        q   <= q_shift;
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_shift_param.sv
// Bench for piso_shift_param: an LSB-first and an MSB-first instance (WIDTH=4) share stimulus;
// a negedge monitor scoreboards serial bits and handshake/done timing, tasks check scenarios.
module tb_piso_shift_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pin;
  logic       load_valid;
  logic       shift_en;

  logic       load_ready_l, sout_l, sout_valid_l, busy_l, done_l;
  logic [3:0] q_l;
  logic [1:0] cnt_l;
  logic       load_ready_m, sout_m, sout_valid_m, busy_m, done_m;
  logic [3:0] q_m;
  logic [1:0] cnt_m;

  int errors = 0;
  int checks = 0;

  bit exp_l[$];
  bit exp_m[$];
  bit       m_busy = 1'b0;
  bit       m_done = 1'b0;
  bit [1:0] m_cnt  = 2'd0;

  always #5 clk = ~clk;

  piso_shift_param #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk(clk), .rst(rst), .pin(pin), .load_valid(load_valid), .load_ready(load_ready_l),
    .shift_en(shift_en), .sout(sout_l), .sout_valid(sout_valid_l), .busy(busy_l),
    .done(done_l), .q(q_l), .cnt(cnt_l)
  );

  piso_shift_param #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_m (
    .clk(clk), .rst(rst), .pin(pin), .load_valid(load_valid), .load_ready(load_ready_m),
    .shift_en(shift_en), .sout(sout_m), .sout_valid(sout_valid_m), .busy(busy_m),
    .done(done_m), .q(q_m), .cnt(cnt_m)
  );

  // Reference model and scoreboard, evaluated mid-cycle with settled inputs.
  always @(negedge clk) begin
    bit exp_ready, next_done, want;
    if (!rst) begin
      exp_l.delete();
      exp_m.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
      m_cnt  = 2'd0;
    end else begin
      exp_ready = !m_busy || (m_cnt == 2'd0 && shift_en);
      checks++;
      if (load_ready_l !== exp_ready || load_ready_m !== exp_ready) begin
        errors++;
        $display("FAIL sb_ready: got l=%b m=%b want %b", load_ready_l, load_ready_m, exp_ready);
      end
      checks++;
      if (busy_l !== m_busy || busy_m !== m_busy || sout_valid_l !== m_busy || sout_valid_m !== m_busy) begin
        errors++;
        $display("FAIL sb_busy: got l=%b/%b m=%b/%b want %b", busy_l, sout_valid_l, busy_m, sout_valid_m, m_busy);
      end
      checks++;
      if (done_l !== m_done || done_m !== m_done) begin
        errors++;
        $display("FAIL sb_done: got l=%b m=%b want %b", done_l, done_m, m_done);
      end
      if (m_busy) begin
        checks++;
        if (exp_l.size() == 0 || exp_m.size() == 0) begin
          errors++;
          $display("FAIL sb_empty: got queue sizes l=%0d m=%0d want nonzero", exp_l.size(), exp_m.size());
        end else begin
          want = exp_l[0];
          if (sout_l !== want) begin
            errors++;
            $display("FAIL sb_sout_l: got %b want %b", sout_l, want);
          end
          want = exp_m[0];
          if (sout_m !== want) begin
            errors++;
            $display("FAIL sb_sout_m: got %b want %b", sout_m, want);
          end
          if (shift_en) begin
            void'(exp_l.pop_front());
            void'(exp_m.pop_front());
          end
        end
      end else begin
        checks++;
        if (sout_l !== 1'b0 || sout_m !== 1'b1) begin
          errors++;
          $display("FAIL sb_idle_level: got l=%b m=%b want l=0 m=1", sout_l, sout_m);
        end
      end
      next_done = m_busy && shift_en && (m_cnt == 2'd0);
      if (load_valid && exp_ready) begin
        for (int i = 0; i < 4; i++) begin
          exp_l.push_back(pin[i]);
          exp_m.push_back(pin[3-i]);
        end
        m_busy = 1'b1;
        m_cnt  = 2'd3;
      end else if (next_done) begin
        m_busy = 1'b0;
      end else if (m_busy && shift_en) begin
        m_cnt = m_cnt - 2'd1;
      end
      m_done = next_done;
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; pin = 4'h0; load_valid = 1'b0; shift_en = 1'b0;
    #1;
    checks++;
    if (q_l !== 4'h0 || q_m !== 4'h0 || cnt_l !== 2'd0 || cnt_m !== 2'd0) begin
      errors++;
      $display("FAIL reset_regs: got q=%h/%h cnt=%0d/%0d want 0", q_l, q_m, cnt_l, cnt_m);
    end
    checks++;
    if (busy_l !== 1'b0 || busy_m !== 1'b0 || done_l !== 1'b0 || done_m !== 1'b0 ||
        sout_l !== 1'b0 || sout_m !== 1'b1 || load_ready_l !== 1'b1) begin
      errors++;
      $display("FAIL reset_outs: got busy=%b%b done=%b%b sout=%b%b ready=%b want 00 00 01 1",
               busy_l, busy_m, done_l, done_m, sout_l, sout_m, load_ready_l);
    end
    next_cycle();
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_basic;
    bit [3:0] w = 4'b1110;
    bit       w_l [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    bit       w_m [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    pin = w; load_valid = 1'b1; shift_en = 1'b1;
    next_cycle();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (sout_l !== w_l[i] || sout_m !== w_m[i]) begin
        errors++;
        $display("FAIL basic_sout[%0d]: got l=%b m=%b want l=%b m=%b", i, sout_l, sout_m, w_l[i], w_m[i]);
      end
      checks++;
      if (cnt_l !== 2'(3 - i) || done_l !== 1'b0) begin
        errors++;
        $display("FAIL basic_cnt[%0d]: got cnt=%0d done=%b want cnt=%0d done=0", i, cnt_l, done_l, 3 - i);
      end
      if (i == 1) begin
        checks++;
        if (q_m !== 4'b1100 || q_l !== 4'b0111) begin
          errors++;
          $display("FAIL basic_q_shift1: got m=%b l=%b want m=1100 l=0111", q_m, q_l);
        end
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (done_l !== 1'b1 || done_m !== 1'b1 || busy_l !== 1'b0 || sout_l !== 1'b0 || sout_m !== 1'b1) begin
      errors++;
      $display("FAIL basic_end: got done=%b%b busy=%b sout=%b%b want 11 0 01", done_l, done_m, busy_l, sout_l, sout_m);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (done_l !== 1'b0 || q_l !== 4'h0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b q=%b want done=0 q=0000", done_l, q_l);
    end
    next_cycle();
  endtask

  task automatic test_stall;
    bit en_pat [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int busy_cycles = 0;
    int done_pulses = 0;
    pin = 4'b1010; load_valid = 1'b1; shift_en = 1'b1;
    next_cycle();
    load_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      shift_en = en_pat[i];
      @(negedge clk);
      if (busy_l) busy_cycles++;
      if (done_l) done_pulses++;
      if (i >= 1 && i <= 3) begin
        checks++;
        if (sout_l !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold[%0d]: got %b want 1", i, sout_l);
        end
      end
      next_cycle();
    end
    checks++;
    if (busy_cycles != 7 || done_pulses != 1) begin
      errors++;
      $display("FAIL stall_len: got busy=%0d done=%0d want busy=7 done=1", busy_cycles, done_pulses);
    end
  endtask

  task automatic test_back_to_back;
    bit seq [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    pin = 4'b0011; load_valid = 1'b1; shift_en = 1'b1;
    next_cycle();
    pin = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (sout_l !== seq[i] || busy_l !== 1'b1 || done_l !== (i == 4)) begin
        errors++;
        $display("FAIL b2b[%0d]: got sout=%b busy=%b done=%b want sout=%b busy=1 done=%b",
                 i, sout_l, busy_l, done_l, seq[i], (i == 4));
      end
      next_cycle();
      if (i == 3) load_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (done_l !== 1'b1 || busy_l !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got done=%b busy=%b want done=1 busy=0", done_l, busy_l);
    end
    next_cycle();
  endtask

  task automatic test_load_while_busy;
    bit seq [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    pin = 4'b0110; load_valid = 1'b1; shift_en = 1'b1;
    next_cycle();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        pin = 4'b1111;
        load_valid = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (sout_l !== seq[i]) begin
        errors++;
        $display("FAIL busy_load_sout[%0d]: got %b want %b", i, sout_l, seq[i]);
      end
      if (i >= 1 && i <= 3) begin
        checks++;
        if (load_ready_l !== (i == 3)) begin
          errors++;
          $display("FAIL busy_load_ready[%0d]: got %b want %b", i, load_ready_l, (i == 3));
        end
      end
      if (i == 1) begin
        checks++;
        if (cnt_l !== 2'd2 || q_l !== 4'b0011) begin
          errors++;
          $display("FAIL busy_load_q: got cnt=%0d q=%b want cnt=2 q=0011", cnt_l, q_l);
        end
      end
      next_cycle();
      if (i == 3) load_valid = 1'b0;
    end
    repeat (2) next_cycle();
  endtask

  task automatic test_async_reset;
    int stray_done = 0;
    pin = 4'b1011; load_valid = 1'b1; shift_en = 1'b1;
    next_cycle();
    load_valid = 1'b0;
    next_cycle();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (q_l !== 4'h0 || q_m !== 4'h0 || busy_l !== 1'b0 || busy_m !== 1'b0 || done_l !== 1'b0 ||
        sout_l !== 1'b0 || sout_m !== 1'b1 || sout_valid_l !== 1'b0 || cnt_l !== 2'd0) begin
      errors++;
      $display("FAIL async_rst: got q=%b/%b busy=%b%b done=%b sout=%b%b cnt=%0d want 0 00 0 01 0",
               q_l, q_m, busy_l, busy_m, done_l, sout_l, sout_m, cnt_l);
    end
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_l || done_m || busy_l) stray_done++;
      next_cycle();
    end
    checks++;
    if (stray_done != 0) begin
      errors++;
      $display("FAIL async_rst_after: got %0d cycles with done/busy want 0", stray_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_load_while_busy();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
